// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (sign fix-up around the unsigned core).
module seq_divider #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CNT_W-1:0] cnt;
    logic             dbz_q;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_diff;
    logic [WIDTH-1:0] a_load;
    logic [WIDTH-1:0] b_load;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

    // Stored remainder is always below the divisor, so only the shifted copy needs the extra bit.
    assign r_sh   = {r_q, q_q[WIDTH-1]};
    assign r_diff = r_sh - {1'b0, d_q};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic sign_q;
    logic sign_r;

    always_comb begin
        a_load = dividend[WIDTH-1] ? -dividend : dividend;
        b_load = divisor[WIDTH-1]  ? -divisor  : divisor;
    end

    // On divide-by-zero Q still holds |dividend|, so the sign_r negation restores the dividend.
    always_comb begin
        q_res = '1;
        r_res = dbz_q ? q_q : r_q;
        if (!dbz_q) begin
            q_res = sign_q ? -q_q : q_q;
        end
        if (sign_r) begin
            r_res = -r_res;
        end
    end
`else
    always_comb begin
        a_load = dividend;
        b_load = divisor;
    end

    always_comb begin
        q_res = dbz_q ? '1 : q_q;
        r_res = dbz_q ? q_q : r_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt         <= '0;
            dbz_q       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        r_q         <= '0;
                        q_q         <= a_load;
                        d_q         <= b_load;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        dbz_q       <= (divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
                        sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r      <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            state <= DONE;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    q_q <= {q_q[WIDTH-2:0], ~r_diff[WIDTH]};
                    r_q <= r_diff[WIDTH] ? r_sh[WIDTH-1:0] : r_diff[WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    done        <= 1'b1;
                    quotient    <= q_res;
                    remainder   <= r_res;
                    div_by_zero <= dbz_q;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
